// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pcsource encodings, bubble word, fetch FSM states and a saturating increment.
package pipe_pkg;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_REG = 2'b10;
    localparam logic [1:0] PCS_JMP = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {IDLE, REQ, DROP} fetch_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return &v ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_if_reg.sv
// pipe_if_reg: stage register with load enable and bubble insert; reusable for any later stage.
module pipe_if_reg #(
    parameter logic [31:0] NOP = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en_i,
    input  logic        bubble_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] inst_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inst_q  <= NOP;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            inst_q  <= bubble_i ? NOP : inst_i;
            pc4_q   <= pc4_i;
            valid_q <= !bubble_i;
        end
    end

    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_fetch.sv
// pipe_fetch: IF stage + IF/ID register with stall skid buffer and redirect drop.
// Optional perf counters enabled by defining PIPE_FETCH_PERF_EN.
module pipe_fetch
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] rpc,
    input  logic        wpcir,
    input  logic        dbubble,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
`ifdef PIPE_FETCH_PERF_EN
   ,output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed,
    output logic [31:0] perf_stall
`else
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, skid_q, skid_d;
    logic         skid_v_q, skid_v_d;
    logic [31:0]  pc4, target, word;
    logic         done, redirect;

    assign pc4    = pc_q + 32'd4;
    assign target = pcsource == PCS_BR  ? bpc :
                    pcsource == PCS_REG ? rpc :
                    pcsource == PCS_JMP ? jpc : pc4;
    assign word   = skid_v_q ? skid_q : imem_rdata;
    // a word parked in the skid register completes without touching memory
    assign done     = state_q == REQ && wpcir && (skid_v_q || imem_ack);
    assign redirect = state_q == REQ && wpcir && !skid_v_q && !imem_ack && dbubble;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (done) begin
                    pc_d     = target;
                    skid_v_d = 1'b0;
                end else if (redirect) begin
                    pc_d    = target;
                    state_d = DROP;
                end else if (!wpcir && imem_ack && !skid_v_q) begin
                    skid_v_d = 1'b1;
                    skid_d   = imem_rdata;
                end
            end
            DROP: begin
                pc_d    = wpcir && dbubble ? target : pc_q;
                state_d = imem_ack ? REQ : DROP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            skid_q   <= 32'd0;
            skid_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign imem_req  = state_q == REQ && wpcir && !skid_v_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;

    pipe_if_reg #(.NOP(NOP_INST)) u_if_id (
        .clock    (clock),
        .reset    (reset),
        .en_i     (wpcir),
        .bubble_i (!(done && !dbubble)),
        .inst_i   (word),
        .pc4_i    (pc4),
        .inst_o   (inst),
        .pc4_o    (dpc4),
        .valid_o  (dvalid)
    );

`ifdef PIPE_FETCH_PERF_EN
    logic [31:0] fetched_q, squashed_q, stall_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetched_q  <= 32'd0;
            squashed_q <= 32'd0;
            stall_q    <= 32'd0;
        end else begin
            fetched_q  <= done && !dbubble ? sat_inc(fetched_q) : fetched_q;
            squashed_q <= (done && dbubble) || redirect ? sat_inc(squashed_q) : squashed_q;
            stall_q    <= !wpcir ? sat_inc(stall_q) : stall_q;
        end
    end

    assign perf_fetched  = fetched_q;
    assign perf_squashed = squashed_q;
    assign perf_stall    = stall_q;
`else
`endif

endmodule

// File: tb/tb_pipe_fetch.sv
// tb_pipe_fetch: directed vectors with hand-computed expectations for pipe_fetch.
module tb_pipe_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  pcsource;
    logic [31:0] bpc, jpc, rpc;
    logic        wpcir, dbubble;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        imem_ack;
    logic [31:0] pc, dpc4, inst;
    logic        dvalid;
`ifdef PIPE_FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_squashed, perf_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    pipe_fetch dut (
        .clock      (clock),
        .reset      (reset),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .rpc        (rpc),
        .wpcir      (wpcir),
        .dbubble    (dbubble),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .pc         (pc),
        .dpc4       (dpc4),
        .inst       (inst),
        .dvalid     (dvalid)
`ifdef PIPE_FETCH_PERF_EN
       ,.perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed),
        .perf_stall    (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // apply inputs for the coming cycle, then let combinational outputs settle
    task automatic drv(input logic ack, input logic [31:0] rd, input logic [1:0] pcs,
                       input logic db, input logic wp);
        imem_ack   = ack;
        imem_rdata = rd;
        pcsource   = pcs;
        dbubble    = db;
        wpcir      = wp;
        #1;
    endtask

    task automatic chk_perf_zero(input string tag);
`ifdef PIPE_FETCH_PERF_EN
        chk({tag, "_perf_fetched"}, perf_fetched, 32'd0);
        chk({tag, "_perf_squashed"}, perf_squashed, 32'd0);
        chk({tag, "_perf_stall"}, perf_stall, 32'd0);
`else
        chk({tag, "_dvalid"}, {31'd0, dvalid}, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        bpc = 32'h40; jpc = 32'h100; rpc = 32'h0;
        drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_dpc4", dpc4, 32'h0);
        chk("rst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk_perf_zero("rst");
        step();
        reset = 1'b0;
        #1;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        // sequential fetch, single-cycle ack
        drv(1'b1, 32'h2008_0001, 2'b00, 1'b0, 1'b1);
        chk("seq0_req", {31'd0, imem_req}, 32'd1);
        chk("seq0_addr", imem_addr, 32'h0);
        step();
        chk("seq0_inst", inst, 32'h2008_0001);
        chk("seq0_dpc4", dpc4, 32'h4);
        chk("seq0_dvalid", {31'd0, dvalid}, 32'd1);
        drv(1'b1, 32'h2009_0002, 2'b00, 1'b0, 1'b1);
        chk("seq1_addr", imem_addr, 32'h4);
        step();
        chk("seq1_inst", inst, 32'h2009_0002);
        chk("seq1_dpc4", dpc4, 32'h8);
        chk("seq1_addr_next", imem_addr, 32'h8);
        // stall while the ack returns; word parks in skid
        drv(1'b1, 32'h8D28_0000, 2'b01, 1'b1, 1'b0);
        chk("stall_req", {31'd0, imem_req}, 32'd0);
        step();
        drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("stall1_pc", pc, 32'h8);
        chk("stall1_inst", inst, 32'h2009_0002);
        chk("stall1_dpc4", dpc4, 32'h8);
        step();
        chk("stall2_pc", pc, 32'h8);
        chk("stall2_inst", inst, 32'h2009_0002);
        chk("stall2_dvalid", {31'd0, dvalid}, 32'd1);
        drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        chk("skid_req", {31'd0, imem_req}, 32'd0);
        step();
        chk("skid_inst", inst, 32'h8D28_0000);
        chk("skid_dpc4", dpc4, 32'hC);
        chk("skid_dvalid", {31'd0, dvalid}, 32'd1);
        // taken branch squashes the word being fetched
        drv(1'b1, 32'hDEAD_BEEF, 2'b01, 1'b1, 1'b1);
        chk("br_addr", imem_addr, 32'hC);
        chk("br_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("br_inst", inst, 32'h0);
        chk("br_dvalid", {31'd0, dvalid}, 32'd0);
        chk("br_dpc4", dpc4, 32'h10);
        chk("br_addr_next", imem_addr, 32'h40);
        // jump while the ack is outstanding: returned word dropped
        drv(1'b0, 32'h0, 2'b11, 1'b1, 1'b1);
        step();
        drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        chk("drop_pc", pc, 32'h100);
        chk("drop_req", {31'd0, imem_req}, 32'd0);
        chk("drop_dvalid", {31'd0, dvalid}, 32'd0);
        step();
        drv(1'b1, 32'h1111_1111, 2'b00, 1'b0, 1'b1);
        chk("drop2_dvalid", {31'd0, dvalid}, 32'd0);
        step();
        chk("drop_done_inst", inst, 32'h0);
        chk("drop_done_dvalid", {31'd0, dvalid}, 32'd0);
        chk("drop_done_req", {31'd0, imem_req}, 32'd1);
        chk("drop_done_addr", imem_addr, 32'h100);
        // jump to the top of memory, then wrap
        jpc = 32'hFFFF_FFFC;
        drv(1'b1, 32'h2222_2222, 2'b11, 1'b0, 1'b1);
        step();
        chk("jmp_inst", inst, 32'h2222_2222);
        chk("jmp_dpc4", dpc4, 32'h104);
        chk("jmp_addr", imem_addr, 32'hFFFF_FFFC);
        drv(1'b1, 32'h3333_3333, 2'b00, 1'b0, 1'b1);
        step();
        chk("wrap_dpc4", dpc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_inst", inst, 32'h3333_3333);
        drv(1'b1, 32'h4444_4444, 2'b00, 1'b0, 1'b1);
        step();
        chk("pre_rst_pc", pc, 32'h4);
        // reset with the request at 0x4 outstanding, then a late ack
        drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_dvalid", {31'd0, dvalid}, 32'd0);
        chk("mid_rst_inst", inst, 32'h0);
        chk_perf_zero("mid_rst");
        step();
        reset = 1'b0;
        drv(1'b1, 32'h5555_5555, 2'b00, 1'b0, 1'b1);
        chk("late_idle_req", {31'd0, imem_req}, 32'd0);
        step();
        drv(1'b0, 32'h0, 2'b00, 1'b0, 1'b1);
        chk("late_inst", inst, 32'h0);
        chk("late_dvalid", {31'd0, dvalid}, 32'd0);
        chk("late_pc", pc, 32'h0);
        chk("late_req", {31'd0, imem_req}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_fetch.md
Name: pipe_fetch

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core; the producer side of the decode-stage interface.
- Holds the PC and selects the next PC from the decode stage's pcsource/bpc/jpc/register target.
- Fetches over a request/acknowledge instruction-memory port and delivers inst/dpc4 to decode.
- Honours the decode stall (wpcir) and the control-hazard squash (dbubble).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0000, instruction word injected as a bubble (sll $0,$0,0).

Ports:
clock  in  1  stage clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
pcsource  in  2  next-PC select from decode: 00 pc+4, 01 bpc, 10 rpc, 11 jpc.
bpc  in  32  branch target from decode.
jpc  in  32  jump target from decode.
rpc  in  32  register target (jr; forwarded rs value from decode).
wpcir  in  1  1 = PC and IF/ID may update; 0 = load-use stall, hold both.
dbubble  in  1  1 = squash the instruction being fetched (taken control transfer in decode).
imem_req  out  1  fetch request.
imem_addr  out  32  fetch word address; always equals the current PC.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
imem_ack  in  1  one-cycle acknowledge; may arrive 1..N cycles after the request.
pc  out  32  current fetch PC.
dpc4  out  32  IF/ID: PC+4 of the instruction in decode.
inst  out  32  IF/ID: instruction word in decode.
dvalid  out  1  IF/ID: 1 = inst is real; 0 = bubble.

Behaviour:
- Reset (asynchronous): pc=RESET_PC; inst=NOP_INST; dpc4=0; dvalid=0; imem_req=0; state=IDLE; redirect flag clear.
- States:
  - IDLE: one cycle after reset release. Next cycle is REQ.
  - REQ: imem_req=1, imem_addr=pc held stable until imem_ack.
  - DROP: request outstanding after a redirect.
- Update rule. A cycle "completes" when state=REQ, imem_ack=1 and wpcir=1.
  - Completion with dbubble=0:
    - inst<=imem_rdata, dpc4<=pc+4, dvalid<=1.
    - pc<=next-PC selected by pcsource.
  - Completion with dbubble=1:
    - inst<=NOP_INST, dvalid<=0, dpc4<=pc+4.
    - pc<=selected target.
- Latency: with a single-cycle ack, one instruction per cycle; inst is visible the cycle after ack.
- No ack and wpcir=1:
  - IF/ID loads a bubble (inst=NOP_INST, dvalid=0).
  - pc holds.
  - If dbubble=1 in this cycle: pc<=selected target, redirect flag set, state->DROP.
- DROP: the returning ack's data is discarded. The IF/ID bubble is kept. Go to REQ with the new pc; the new request is issued the cycle after the ack.
- wpcir=0 (stall):
  - pc, inst, dpc4, dvalid all hold.
  - pcsource and dbubble are ignored.
  - An ack arriving during a stall has its word captured into a 1-entry skid register.
  - imem_req drops until the stall clears.
  - The first cycle after the stall completes from the skid register, not from memory.
- Simultaneous events:
  - wpcir=0 beats dbubble.
  - dbubble with ack completes normally (squash plus redirect).
  - Ack in DROP together with a new dbubble: the latest target wins.
- Arithmetic: pc+4 is mod 2^32; wrap from 32'hFFFF_FFFC to 0. No alignment checks; pc[1:0] is passed through.
- Reset mid-fetch: an outstanding request is abandoned; a late ack after reset is ignored in IDLE.

Optional Feature:
PIPE_FETCH_PERF_EN
- Defined: adds three 32-bit outputs, all reset to 0 and saturating at all-ones:
  - perf_fetched: completions with dbubble=0.
  - perf_squashed: dbubble completions plus DROP entries.
  - perf_stall: cycles with wpcir=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - pcsource encodings (PCS_SEQ, PCS_BR, PCS_REG, PCS_JMP).
  - NOP_INST constant.
  - fetch FSM state enum (IDLE/REQ/DROP).
- One sub-module, pipe_if_reg: IF/ID register with load-enable (wpcir) and bubble insert. It is reused for any later stage register.
- The next-PC mux stays inline.

Test Plan:
- Reset then single-cycle ack with words 0x20080001, 0x20090002 -> imem_addr 0x0, 0x4, 0x8; inst shows both in order; dpc4=0x4, 0x8; dvalid=1.
- wpcir=0 for 2 cycles while an ack returns 0x8D280000 -> pc/inst/dpc4 frozen; the word is not lost and appears in inst the cycle after wpcir=1.
- pcsource=01, bpc=0x40, dbubble=1 at completion -> inst=0x0, dvalid=0; next imem_addr=0x40.
- 3-cycle ack latency, with pcsource=11, jpc=0x100, dbubble=1 during the wait -> the returned word is discarded; next request is at 0x100; no non-bubble inst in between.
- pc=0xFFFFFFFC sequential -> dpc4=0x0; next imem_addr=0x0.
- Assert reset while a request is outstanding, with the ack arriving a cycle later -> pc=RESET_PC, dvalid=0; the late ack is ignored. With PIPE_FETCH_PERF_EN defined, all counters read 0.
